// File: rtl/llc_rsp_out_packetizer.sv
// llc_rsp_out_packetizer
// Serializes one LLC response into NoC response-plane flits:
// one header flit, one address flit, then one data flit per set word_mask bit
// in ascending word order. A single-entry capture buffer holds the response
// while the packet is in flight, so upstream inputs may change freely.
module llc_rsp_out_packetizer #(
  parameter int COH_MSG_W      = 5,
  parameter int CACHE_ID_W     = 4,
  parameter int INVACK_W       = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int WORD_OFF_W     = 2,
  parameter int WORD_W         = 64,
  parameter int LINE_ADDR_W    = 28,
  parameter int FLIT_W         = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rsp_valid,
  output logic                             rsp_ready,
  input  logic [COH_MSG_W-1:0]             rsp_coh_msg,
  input  logic [LINE_ADDR_W-1:0]           rsp_addr,
  input  logic [WORDS_PER_LINE*WORD_W-1:0] rsp_line,
  input  logic [INVACK_W-1:0]              rsp_invack_cnt,
  input  logic [CACHE_ID_W-1:0]            rsp_req_id,
  input  logic [CACHE_ID_W-1:0]            rsp_dest_id,
  input  logic [WORD_OFF_W-1:0]            rsp_word_offset,
  input  logic [WORDS_PER_LINE-1:0]        rsp_word_mask,
  output logic                             flit_valid,
  input  logic                             flit_ready,
  output logic [FLIT_W-1:0]                flit_data,
  output logic                             flit_tail,
  output logic                             busy
);

  // Header fields packed LSB-first: coh_msg, req_id, dest_id, invack_cnt,
  // word_offset, word_mask.
  localparam int HDR_W = COH_MSG_W + 2 * CACHE_ID_W + INVACK_W + WORD_OFF_W + WORDS_PER_LINE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } state_t;

  state_t state_reg, state_next;
  logic [WORD_OFF_W-1:0] idx_reg, idx_next;

  // Captured response (single-entry buffer)
  logic [COH_MSG_W-1:0]             coh_msg_reg;
  logic [LINE_ADDR_W-1:0]           addr_reg;
  logic [WORDS_PER_LINE*WORD_W-1:0] line_reg;
  logic [INVACK_W-1:0]              invack_cnt_reg;
  logic [CACHE_ID_W-1:0]            req_id_reg;
  logic [CACHE_ID_W-1:0]            dest_id_reg;
  logic [WORD_OFF_W-1:0]            word_offset_reg;
  logic [WORDS_PER_LINE-1:0]        word_mask_reg;

  logic                      accept;
  logic [HDR_W-1:0]          hdr_bits;
  logic [WORD_W-1:0]         line_words [WORDS_PER_LINE];
  logic [WORDS_PER_LINE-1:0] above_mask;
  logic [WORD_OFF_W-1:0]     first_idx;
  logic [WORD_OFF_W-1:0]     next_idx;
  logic                      has_data;
  logic                      data_last;

  // Lowest set bit of a word mask; callers only use the result when v != 0.
  function automatic logic [WORD_OFF_W-1:0] lowest_set(input logic [WORDS_PER_LINE-1:0] v);
    lowest_set = '0;
    for (int i = WORDS_PER_LINE - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = WORD_OFF_W'(i);
    end
  endfunction

  // Upstream may only hand over a response when no packet is in flight.
  assign rsp_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign accept    = rsp_valid && (state_reg == IDLE);

  assign hdr_bits = {word_mask_reg, word_offset_reg, invack_cnt_reg,
                     dest_id_reg, req_id_reg, coh_msg_reg};

  // Split the captured line into words and mark mask bits above the current word.
  generate
    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
      assign line_words[gi] = line_reg[gi*WORD_W +: WORD_W];
      assign above_mask[gi] = word_mask_reg[gi] && (WORD_OFF_W'(gi) > idx_reg);
    end
  endgenerate

  assign first_idx = lowest_set(word_mask_reg);
  assign next_idx  = lowest_set(above_mask);
  assign has_data  = |word_mask_reg;
  assign data_last = ~|above_mask;

  // State and word-index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Capture every response field on acceptance; held until the next acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coh_msg_reg     <= '0;
      addr_reg        <= '0;
      line_reg        <= '0;
      invack_cnt_reg  <= '0;
      req_id_reg      <= '0;
      dest_id_reg     <= '0;
      word_offset_reg <= '0;
      word_mask_reg   <= '0;
    end else if (accept) begin
      coh_msg_reg     <= rsp_coh_msg;
      addr_reg        <= rsp_addr;
      line_reg        <= rsp_line;
      invack_cnt_reg  <= rsp_invack_cnt;
      req_id_reg      <= rsp_req_id;
      dest_id_reg     <= rsp_dest_id;
      word_offset_reg <= rsp_word_offset;
      word_mask_reg   <= rsp_word_mask;
    end
  end

  // Next-state and flit outputs. Outputs depend only on registered state,
  // so they stay stable while the NoC stalls.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    flit_valid = 1'b0;
    flit_tail  = 1'b0;
    flit_data  = '0;
    case (state_reg)
      IDLE: begin
        if (rsp_valid) state_next = HDR;
      end
      HDR: begin
        flit_valid = 1'b1;
        flit_data  = FLIT_W'(hdr_bits);
        if (flit_ready) state_next = ADDR;
      end
      ADDR: begin
        flit_valid = 1'b1;
        flit_data  = FLIT_W'(addr_reg);
        flit_tail  = !has_data;
        if (flit_ready) begin
          if (has_data) begin
            state_next = DATA;
            idx_next   = first_idx;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        flit_valid = 1'b1;
        flit_data  = FLIT_W'(line_words[idx_reg]);
        flit_tail  = data_last;
        if (flit_ready) begin
          if (data_last) state_next = IDLE;
          else           idx_next   = next_idx;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_llc_rsp_out_packetizer.sv
// Scoreboard bench for llc_rsp_out_packetizer: the driver pushes the expected
// flit sequence of every accepted response, the monitor pops on each flit handshake.
module tb_llc_rsp_out_packetizer;

  logic         clk;
  logic         rst;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [4:0]   rsp_coh_msg;
  logic [27:0]  rsp_addr;
  logic [255:0] rsp_line;
  logic [3:0]   rsp_invack_cnt;
  logic [3:0]   rsp_req_id;
  logic [3:0]   rsp_dest_id;
  logic [1:0]   rsp_word_offset;
  logic [3:0]   rsp_word_mask;
  logic         flit_valid;
  logic         flit_ready;
  logic [63:0]  flit_data;
  logic         flit_tail;
  logic         busy;

  typedef struct packed {
    logic [4:0]   coh;
    logic [27:0]  addr;
    logic [255:0] line;
    logic [3:0]   inv;
    logic [3:0]   req;
    logic [3:0]   dest;
    logic [1:0]   off;
    logic [3:0]   mask;
  } rsp_t;

  llc_rsp_out_packetizer dut (
    .clk            (clk),
    .rst            (rst),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_coh_msg    (rsp_coh_msg),
    .rsp_addr       (rsp_addr),
    .rsp_line       (rsp_line),
    .rsp_invack_cnt (rsp_invack_cnt),
    .rsp_req_id     (rsp_req_id),
    .rsp_dest_id    (rsp_dest_id),
    .rsp_word_offset(rsp_word_offset),
    .rsp_word_mask  (rsp_word_mask),
    .flit_valid     (flit_valid),
    .flit_ready     (flit_ready),
    .flit_data      (flit_data),
    .flit_tail      (flit_tail),
    .busy           (busy)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          pops = 0;
  int          pkts = 0;
  int          last_tail_cyc = -100;
  int          ready_mode = 0;   // 0: always ready, 1: fixed pattern, 2: random
  logic [64:0] exp_q [$];        // {data, tail}
  logic [64:0] mon_e;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_tail = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, req_v, cyc);
    end
  endtask

  // Reference model: packet = header, address, then each masked word in ascending order.
  task automatic model_push(input rsp_t r);
    logic [63:0] h;
    int n;
    int seen;
    h = 64'(r.coh) | (64'(r.req) << 5) | (64'(r.dest) << 9) | (64'(r.inv) << 13)
      | (64'(r.off) << 17) | (64'(r.mask) << 19);
    n = 0;
    for (int i = 0; i < 4; i++) if (r.mask[i]) n++;
    exp_q.push_back({h, 1'b0});
    exp_q.push_back({64'(r.addr), (n == 0)});
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (r.mask[i]) begin
        seen++;
        exp_q.push_back({r.line[i*64 +: 64], (seen == n)});
      end
    end
  endtask

  // flit_ready driver
  initial begin
    logic [4:0] pat;
    int k;
    pat = 5'b10100;  // 0,0,1,0,1 from bit 0 upward
    k = 0;
    flit_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       flit_ready = 1'b1;
        1:       begin flit_ready = pat[k % 5]; k++; end
        default: flit_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: scoreboard compare on every handshake, plus stall and ready checks.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(flit_valid), 64'd1);
        check("stall_data", flit_data, prev_data);
        check("stall_tail", 64'(flit_tail), 64'(prev_tail));
      end
      if (flit_valid) check("ready_busy_in_pkt", {62'd0, rsp_ready, busy}, 64'd1);
      if (flit_valid && flit_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_flit actual=%h required=none cycle=%0d", flit_data, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("flit_data", flit_data, mon_e[64:1]);
          check("flit_tail", 64'(flit_tail), 64'(mon_e[0]));
        end
        pops++;
        if (flit_tail) begin
          last_tail_cyc = cyc;
          pkts++;
          $display("packet %0d complete at cycle %0d", pkts, cyc);
        end
      end
      prev_stall = flit_valid && !flit_ready;
      prev_data  = flit_data;
      prev_tail  = flit_tail;
    end
  end

  // Present one response; returns one cycle after the header becomes visible.
  task automatic send(input rsp_t r, input bit chk_b2b, input bit keep);
    bit ok;
    rsp_coh_msg     = r.coh;
    rsp_addr        = r.addr;
    rsp_line        = r.line;
    rsp_invack_cnt  = r.inv;
    rsp_req_id      = r.req;
    rsp_dest_id     = r.dest;
    rsp_word_offset = r.off;
    rsp_word_mask   = r.mask;
    rsp_valid       = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (rsp_ready) begin ok = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=not_ready required=ready cycle=%0d", cyc);
      rsp_valid = 1'b0;
      return;
    end
    model_push(r);
    if (chk_b2b) check("b2b_accept_cycle", 64'(cyc), 64'(last_tail_cyc + 1));
    @(posedge clk);
    #1;
    if (!keep) rsp_valid = 1'b0;
    @(negedge clk);
    check("hdr_latency", {62'd0, flit_valid, rsp_ready}, 64'd2);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d_left required=0 cycle=%0d", exp_q.size(), cyc);
    end
  endtask

  function automatic rsp_t rand_rsp();
    rsp_t r;
    r.coh  = 5'($urandom);
    r.addr = 28'($urandom);
    for (int i = 0; i < 8; i++) r.line[i*32 +: 32] = $urandom;
    r.inv  = 4'($urandom);
    r.req  = 4'($urandom);
    r.dest = 4'($urandom);
    r.off  = 2'($urandom);
    r.mask = 4'($urandom);
    return r;
  endfunction

  initial begin
    rsp_t r;
    rsp_t r2;
    int base;
    bit ok;
    rst = 1'b0;
    rsp_valid = 1'b0;
    r = '0;
    rsp_coh_msg = '0; rsp_addr = '0; rsp_line = '0; rsp_invack_cnt = '0;
    rsp_req_id = '0; rsp_dest_id = '0; rsp_word_offset = '0; rsp_word_mask = '0;

    // Reset state
    #2;
    check("reset_outputs", {60'd0, flit_valid, flit_tail, busy, rsp_ready}, 64'd1);
    check("reset_data", flit_data, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {62'd0, rsp_ready, busy}, 64'd2);
    @(posedge clk);
    #1;

    // Full line, always ready
    ready_mode = 0;
    r = '0;
    r.coh = 5'h03; r.req = 4'd2; r.dest = 4'd1; r.inv = 4'd0; r.mask = 4'b1111;
    r.addr = 28'h1234567;
    r.line = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
              64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    send(r, 1'b0, 1'b0);
    wait_drain();

    // Control-only
    r = '0;
    r.coh = 5'h07; r.inv = 4'd3; r.addr = 28'h0ABCDEF; r.mask = 4'b0000;
    send(r, 1'b0, 1'b0);
    wait_drain();

    // Sparse mask
    r = rand_rsp();
    r.mask = 4'b1010;
    send(r, 1'b0, 1'b0);
    wait_drain();

    // Backpressure on a full-line packet
    ready_mode = 1;
    r = rand_rsp();
    r.mask = 4'b1111;
    send(r, 1'b0, 1'b0);
    wait_drain();

    // Back-to-back with valid held; second response driven right after first capture
    ready_mode = 0;
    r = rand_rsp();
    r.mask = 4'b1111;
    r2 = rand_rsp();
    r2.mask = 4'b0110;
    send(r, 1'b0, 1'b1);
    send(r2, 1'b1, 1'b0);
    wait_drain();

    // Randomized responses and random backpressure
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      r = rand_rsp();
      send(r, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_drain();

    // Reset after the addr flit of a 4-word packet
    ready_mode = 0;
    base = pops;
    r = rand_rsp();
    r.mask = 4'b1111;
    send(r, 1'b0, 1'b0);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      #1;
      if (pops >= base + 2) begin ok = 1'b1; break; end
    end
    check("mid_pkt_addr_seen", 64'(ok), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    check("mid_reset_outputs", {61'd0, flit_valid, flit_tail, busy}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("after_reset_ready", {61'd0, rsp_ready, busy, flit_valid}, 64'd4);
    @(posedge clk);
    #1;

    // One more packet after recovery
    r = rand_rsp();
    send(r, 1'b0, 1'b0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
